// File: rtl/lm_sm_sequencer_pkg.sv
// Shared ISA constants, instruction field positions and the sequencer state
// encoding for the decode-stage LM/SM micro-sequencer.
package lm_sm_sequencer_pkg;

    // Primary opcodes of the 16-bit ISA
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;

    // Instruction field positions
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 9;
    localparam int LIST_HI = 7;
    localparam int LIST_LO = 0;

    // Sequencer states: IDLE passes instructions through, SEQ walks a register list
    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

endpackage

// File: rtl/lm_sm_sequencer_priority_enc8.sv
// Lowest-set-bit encoder for an 8-bit vector. Also yields the vector with that
// bit cleared and a flag telling whether it was the only bit set.
module priority_enc8 (
    input  logic [7:0] i_vec,
    output logic [2:0] o_idx,
    output logic [7:0] o_clr,
    output logic       o_any,
    output logic       o_single
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = i[2:0];
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit
    assign o_clr    = i_vec & (i_vec - 8'd1);
    assign o_any    = |i_vec;
    assign o_single = o_any && (o_clr == 8'd0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// Decode-stage micro-sequencer: passes ordinary instructions through and
// expands LM/SM into one micro-op per set bit of the register list, stalling
// fetch and IF/ID until the final micro-op has been issued.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int         WIDTH    = 16,
    parameter int         NUM_REGS = 8,
    parameter logic [3:0] OP_LM    = lm_sm_sequencer_pkg::OP_LM,
    parameter logic [3:0] OP_SM    = lm_sm_sequencer_pkg::OP_SM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inIR,
    input  logic             holdIn,
    input  logic             flush,
    output logic             stallUp,
    output logic             outValid,
    output logic [WIDTH-1:0] outIR,
    output logic             isMulti,
    output logic             memRead,
    output logic             memWrite,
    output logic [2:0]       baseReg,
    output logic [2:0]       regIndex,
    output logic [2:0]       offset,
    output logic             first,
    output logic             last
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REGS-1:0] r_rem_mask;
    logic [NUM_REGS-1:0] w_rem_nxt;
    logic [2:0]          r_off_cnt;
    logic [2:0]          w_off_nxt;

    logic [3:0]          w_opcode;
    logic [2:0]          w_ra;
    logic [NUM_REGS-1:0] w_list;
    logic                w_is_lm;
    logic                w_is_sm;
    logic [NUM_REGS-1:0] w_enc_vec;
    logic [2:0]          w_idx;
    logic [NUM_REGS-1:0] w_clr;
    logic                w_any;
    logic                w_single;

    assign w_opcode = inIR[OPC_HI:OPC_LO];
    assign w_ra     = inIR[RA_HI:RA_LO];
    assign w_list   = inIR[LIST_HI:LIST_LO];
    assign w_is_lm  = (w_opcode == OP_LM);
    assign w_is_sm  = (w_opcode == OP_SM);

    // In IDLE the fresh list is decoded; in SEQ the remaining bits are
    assign w_enc_vec = (r_state == SEQ) ? r_rem_mask : w_list;

    priority_enc8 u_penc (
        .i_vec    (w_enc_vec),
        .o_idx    (w_idx),
        .o_clr    (w_clr),
        .o_any    (w_any),
        .o_single (w_single)
    );

    // Output decode and next-state selection; everything zero while reset is low
    always_comb begin
        stallUp     = 1'b0;
        outValid    = 1'b0;
        outIR       = '0;
        isMulti     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        baseReg     = 3'd0;
        regIndex    = 3'd0;
        offset      = 3'd0;
        first       = 1'b0;
        last        = 1'b0;
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem_mask;
        w_off_nxt   = r_off_cnt;

        if (reset) begin
            outIR = inIR;
            if (r_state == IDLE) begin
                if (inValid && (w_is_lm || w_is_sm)) begin
                    // An empty list issues nothing (behaves as a NOP)
                    if (w_any) begin
                        outValid = 1'b1;
                        isMulti  = 1'b1;
                        memRead  = w_is_lm;
                        memWrite = w_is_sm;
                        baseReg  = w_ra;
                        regIndex = w_idx;
                        first    = 1'b1;
                        last     = w_single;
                        stallUp  = ~w_single;
                        if (!w_single) begin
                            w_state_nxt = SEQ;
                            w_rem_nxt   = w_clr;
                            w_off_nxt   = 3'd1;
                        end
                    end
                end else begin
                    outValid = inValid;
                end
            end else begin
                // IF/ID is frozen, so inIR still carries the LM/SM being expanded
                outValid = 1'b1;
                isMulti  = 1'b1;
                memRead  = w_is_lm;
                memWrite = w_is_sm;
                baseReg  = w_ra;
                regIndex = w_idx;
                offset   = r_off_cnt;
                last     = w_single;
                stallUp  = ~w_single;
                if (w_single) begin
                    w_state_nxt = IDLE;
                    w_rem_nxt   = '0;
                    w_off_nxt   = 3'd0;
                end else begin
                    w_rem_nxt = w_clr;
                    w_off_nxt = r_off_cnt + 3'd1;
                end
            end

            if (holdIn) begin
                stallUp     = 1'b1;
                w_state_nxt = r_state;
                w_rem_nxt   = r_rem_mask;
                w_off_nxt   = r_off_cnt;
            end

            // A squash overrides a downstream hold
            if (flush) begin
                outValid    = 1'b0;
                stallUp     = 1'b0;
                w_state_nxt = IDLE;
                w_rem_nxt   = '0;
                w_off_nxt   = 3'd0;
            end
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rem_mask <= '0;
            r_off_cnt  <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem_mask <= w_rem_nxt;
            r_off_cnt  <= w_off_nxt;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer.
module tb_lm_sm_sequencer;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic [15:0] inIR;
    logic        holdIn;
    logic        flush;
    logic        stallUp;
    logic        outValid;
    logic [15:0] outIR;
    logic        isMulti;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  baseReg;
    logic [2:0]  regIndex;
    logic [2:0]  offset;
    logic        first;
    logic        last;

    int total = 0;
    int bad   = 0;

    // {outValid,stallUp,isMulti,memRead,memWrite,first,last,baseReg,regIndex,offset}
    logic [15:0] obs;
    logic [15:0] exp_v;
    assign obs = {outValid, stallUp, isMulti, memRead, memWrite, first, last,
                  baseReg, regIndex, offset};

    lm_sm_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inIR     (inIR),
        .holdIn   (holdIn),
        .flush    (flush),
        .stallUp  (stallUp),
        .outValid (outValid),
        .outIR    (outIR),
        .isMulti  (isMulti),
        .memRead  (memRead),
        .memWrite (memWrite),
        .baseReg  (baseReg),
        .regIndex (regIndex),
        .offset   (offset),
        .first    (first),
        .last     (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs are changed
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; inValid = 1'b1; inIR = 16'h0A50; holdIn = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 16'h0000) begin
            bad++;
            $display("FAIL reset_fields got=%h want=%h", obs, 16'h0000);
        end
        total++;
        if (outIR !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outIR got=%h want=%h", outIR, 16'h0000);
        end
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_passthrough();
        inValid = 1'b1; inIR = 16'h0A50;
        @(negedge clk);
        total++;
        if (obs !== 16'h8000 || outIR !== 16'h0A50) begin
            bad++;
            $display("FAIL add_pass got=%h/%h want=%h/%h", obs, outIR, 16'h8000, 16'h0A50);
        end
        next_cycle();
        inValid = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 16'h0000 || outIR !== 16'h0A50) begin
            bad++;
            $display("FAIL invalid_pass got=%h/%h want=%h/%h", obs, outIR, 16'h0000, 16'h0A50);
        end
        next_cycle();
    endtask

    task automatic test_lm_multi();
        logic [2:0] idx_t [3] = '{3'd0, 3'd2, 3'd5};
        logic       fst_t [3] = '{1'b1, 1'b0, 1'b0};
        logic       lst_t [3] = '{1'b0, 1'b0, 1'b1};
        logic       stl_t [3] = '{1'b1, 1'b1, 1'b0};
        inValid = 1'b1; inIR = 16'h6225;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = {1'b1, stl_t[c], 1'b1, 1'b1, 1'b0, fst_t[c], lst_t[c],
                     3'd1, idx_t[c], c[2:0]};
            total++;
            if (obs !== exp_v || outIR !== 16'h6225) begin
                bad++;
                $display("FAIL lm_0x25 cyc=%0d got=%h want=%h", c, obs, exp_v);
            end
            next_cycle();
        end
        // Back to IDLE: the next instruction passes through at once
        inIR = 16'h0A50;
        @(negedge clk);
        total++;
        if (obs !== 16'h8000) begin
            bad++;
            $display("FAIL lm_then_add got=%h want=%h", obs, 16'h8000);
        end
        next_cycle();
    endtask

    task automatic test_sm_single();
        inValid = 1'b1; inIR = 16'h7680;
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 3'd7, 3'd0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL sm_single got=%h want=%h", obs, exp_v);
        end
        next_cycle();
        inIR = 16'h0A50;
        @(negedge clk);
        total++;
        if (obs !== 16'h8000) begin
            bad++;
            $display("FAIL sm_then_add got=%h want=%h", obs, 16'h8000);
        end
        next_cycle();
    endtask

    task automatic test_empty_list();
        inValid = 1'b1; inIR = 16'h6200;
        @(negedge clk);
        total++;
        if (outValid !== 1'b0 || stallUp !== 1'b0) begin
            bad++;
            $display("FAIL empty_list got=%b%b want=00", outValid, stallUp);
        end
        next_cycle();
        inIR = 16'h0A50;
        @(negedge clk);
        total++;
        if (obs !== 16'h8000) begin
            bad++;
            $display("FAIL empty_then_add got=%h want=%h", obs, 16'h8000);
        end
        next_cycle();
    endtask

    task automatic test_hold();
        // Cycles 1 and 2 are held; cycle 3 re-issues regIndex 1 unheld
        logic [2:0] idx_t [10] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic       hld_t [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       lst;
        logic       stl;
        inValid = 1'b1; inIR = 16'h62FF;
        for (int c = 0; c < 10; c++) begin
            holdIn = hld_t[c];
            #1;
            lst = (c == 9);
            stl = hld_t[c] | ~lst;
            exp_v = {1'b1, stl, 1'b1, 1'b1, 1'b0, (c == 0), lst,
                     3'd1, idx_t[c], idx_t[c]};
            @(negedge clk);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL hold_ff cyc=%0d got=%h want=%h", c, obs, exp_v);
            end
            next_cycle();
        end
        holdIn = 1'b0;
        inIR = 16'h0A50;
        @(negedge clk);
        total++;
        if (obs !== 16'h8000) begin
            bad++;
            $display("FAIL hold_then_add got=%h want=%h", obs, 16'h8000);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        inValid = 1'b1; inIR = 16'h62FF;
        next_cycle();
        next_cycle();
        flush = 1'b1; holdIn = 1'b1;
        @(negedge clk);
        total++;
        if (outValid !== 1'b0 || stallUp !== 1'b0) begin
            bad++;
            $display("FAIL flush_same got=%b%b want=00", outValid, stallUp);
        end
        next_cycle();
        flush = 1'b0; holdIn = 1'b0; inIR = 16'h0A50;
        @(negedge clk);
        total++;
        if (obs !== 16'h8000) begin
            bad++;
            $display("FAIL flush_idle got=%h want=%h", obs, 16'h8000);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        inValid = 1'b1; inIR = 16'h62FF;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        total++;
        if (obs !== 16'h0000 || outIR !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid got=%h/%h want=0000/0000", obs, outIR);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL restart_first got=%h want=%h", obs, exp_v);
        end
        next_cycle();
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL restart_second got=%h want=%h", obs, exp_v);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lm_multi();
        test_sm_single();
        test_empty_list();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
